// File: rtl/debounce_ch.sv
// Multi-channel key debouncer: per-channel 2-FF synchroniser, stability counter and debounced
// level, with registered press/release pulses and an optional long-press / auto-repeat pulse.
module debounce_ch #(
    parameter int unsigned N          = 1,
    parameter int unsigned STABLE_CNT = 262143,
    parameter int unsigned HOLD_CNT   = 0,
    parameter int unsigned REPEAT_CNT = 0,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_level,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_hold
);

    localparam int unsigned CntW = $clog2(STABLE_CNT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CNT - 1);
    localparam logic [N-1:0] Idle = {N{ACTIVE_LOW}};

    logic [N-1:0]    sync1_q, sync1_d;
    logic [N-1:0]    sync2_q, sync2_d;
    logic [N-1:0]    level_q, level_d;
    logic [N-1:0]    press_q, press_d;
    logic [N-1:0]    release_q, release_d;
    logic [CntW-1:0] cnt_q [N];
    logic [CntW-1:0] cnt_d [N];
    logic [N-1:0]    pressed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= Idle;
            sync2_q   <= Idle;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        sync1_d   = key;
        sync2_d   = sync1_q;
        pressed   = sync2_q ^ Idle;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt_d[i] = cnt_q[i];
            // Any sample agreeing with the current level restarts the stability window.
            if (pressed[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                level_d[i]   = pressed[i];
                cnt_d[i]     = '0;
                press_d[i]   = pressed[i];
                release_d[i] = ~pressed[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

    if (HOLD_CNT > 0) begin : g_hold
        localparam int unsigned HoldW = $clog2(HOLD_CNT + 1);
        localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CNT - 1);
        localparam logic [HoldW-1:0] HoldSat  = HoldW'(HOLD_CNT);
        // Reloading at HOLD_CNT-REPEAT_CNT re-arms the threshold REPEAT_CNT edges later.
        localparam logic [HoldW-1:0] HoldReload =
            (REPEAT_CNT > 0) ? HoldW'(HOLD_CNT - REPEAT_CNT) : HoldW'(HOLD_CNT);

        logic [HoldW-1:0] hold_cnt_q [N];
        logic [HoldW-1:0] hold_cnt_d [N];
        logic [N-1:0]     hold_q, hold_d;

        always_ff @(posedge clk) begin
            if (!rst) begin
                hold_q <= '0;
                for (int i = 0; i < int'(N); i++) begin
                    hold_cnt_q[i] <= '0;
                end
            end else begin
                hold_q <= hold_d;
                for (int i = 0; i < int'(N); i++) begin
                    hold_cnt_q[i] <= hold_cnt_d[i];
                end
            end
        end

        always_comb begin
            hold_d = '0;
            for (int i = 0; i < int'(N); i++) begin
                hold_cnt_d[i] = hold_cnt_q[i];
                // Released, releasing this edge, or pressing this edge: counter parks at 0.
                if (!level_q[i] || release_d[i]) begin
                    hold_cnt_d[i] = '0;
                end else if (hold_cnt_q[i] == HoldLast) begin
                    hold_d[i]     = 1'b1;
                    hold_cnt_d[i] = HoldReload;
                end else if (hold_cnt_q[i] != HoldSat) begin
                    hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
                end
            end
        end

        assign key_hold = hold_q;
    end else begin : g_no_hold
        assign key_hold = '0;
    end

endmodule

// File: tb/tb_debounce_ch.sv
// Bench for debounce_ch: two configurations driven by directed scenarios then random keys,
// checked every cycle against an event-timing model of the debouncer.
module tb_debounce_ch;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_a;
    logic [1:0] lvl_a, prs_a, rel_a, hld_a;
    logic [2:0] key_b;
    logic [2:0] lvl_b, prs_b, rel_b, hld_b;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = -1;

    // Model state, indexed [unit][channel].
    int         s1_m [2][3];
    int         s2_m [2][3];
    int         lvl_m [2][3];
    int         run_m [2][3];
    int         press_t_m [2][3];
    logic [2:0] exp_lvl [2];
    logic [2:0] exp_prs [2];
    logic [2:0] exp_rel [2];
    logic [2:0] exp_hld [2];

    // Event logs used by the directed scenarios.
    int ev_press [2];
    int ev_rel [2];
    int press_n  = 0;
    int ev_cnt_a1 = 0;
    int hold_log [$];
    int hold_b [$];

    always #5 clk = ~clk;

    debounce_ch #(
        .N(2), .STABLE_CNT(4), .HOLD_CNT(10), .REPEAT_CNT(3), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .key(key_a), .key_level(lvl_a), .key_press(prs_a),
        .key_release(rel_a), .key_hold(hld_a)
    );

    debounce_ch #(
        .N(3), .STABLE_CNT(1), .HOLD_CNT(5), .REPEAT_CNT(0), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .key(key_b), .key_level(lvl_b), .key_press(prs_b),
        .key_release(rel_b), .key_hold(hld_b)
    );

    // Level flips after S consecutive disagreeing synchronised samples; holds fire at
    // press + H + k*R while the key stays down.
    task automatic step(input int u, input int nch, input int s, input int h, input int r,
                        input int al, input logic rstn, input logic [2:0] k);
        int  p, old, since;
        bit  pr, rl, hd;
        for (int c = 0; c < nch; c++) begin
            pr = 0; rl = 0; hd = 0;
            if (!rstn) begin
                s1_m[u][c] = al; s2_m[u][c] = al; lvl_m[u][c] = 0; run_m[u][c] = 0;
            end else begin
                p   = s2_m[u][c] ^ al;
                old = lvl_m[u][c];
                if (p == old) begin
                    run_m[u][c] = 0;
                end else begin
                    run_m[u][c]++;
                    if (run_m[u][c] == s) begin
                        lvl_m[u][c] = p; run_m[u][c] = 0;
                        pr = (p == 1); rl = (p == 0);
                    end
                end
                if (pr) begin
                    press_t_m[u][c] = edge_n;
                end else if (old == 1 && !rl && h > 0) begin
                    since = edge_n - press_t_m[u][c];
                    if (since == h || (r > 0 && since > h && (since - h) % r == 0)) hd = 1;
                end
                s2_m[u][c] = s1_m[u][c];
                s1_m[u][c] = int'(k[c]);
            end
            exp_lvl[u][c] = lvl_m[u][c][0];
            exp_prs[u][c] = pr; exp_rel[u][c] = rl; exp_hld[u][c] = hd;
            if (u == 0 && c == 0) begin
                if (pr) begin ev_press[0] = edge_n; press_n++; end
                if (rl) ev_rel[0] = edge_n;
                if (hd) hold_log.push_back(edge_n);
            end
            if (u == 0 && c == 1 && (pr || rl || hd)) ev_cnt_a1++;
            if (u == 1 && c == 0) begin
                if (pr) ev_press[1] = edge_n;
                if (hd) hold_b.push_back(edge_n);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, want, edge_n);
        end
    endtask

    // Model update and compare, 1 time unit after each rising edge.
    initial begin
        exp_lvl[0] = '0; exp_prs[0] = '0; exp_rel[0] = '0; exp_hld[0] = '0;
        exp_lvl[1] = '0; exp_prs[1] = '0; exp_rel[1] = '0; exp_hld[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            edge_n++;
            step(0, 2, 4, 10, 3, 1, rst, {1'b0, key_a});
            step(1, 3, 1, 5, 0, 0, rst, key_b);
            vectors++;
            if ({lvl_a, prs_a, rel_a, hld_a} !==
                {exp_lvl[0][1:0], exp_prs[0][1:0], exp_rel[0][1:0], exp_hld[0][1:0]}) begin
                miscompares++;
                $display("FAIL unit_a edge %0d: got lvl=%b prs=%b rel=%b hld=%b, expected %b %b %b %b",
                         edge_n, lvl_a, prs_a, rel_a, hld_a,
                         exp_lvl[0][1:0], exp_prs[0][1:0], exp_rel[0][1:0], exp_hld[0][1:0]);
            end
            vectors++;
            if ({lvl_b, prs_b, rel_b, hld_b} !==
                {exp_lvl[1], exp_prs[1], exp_rel[1], exp_hld[1]}) begin
                miscompares++;
                $display("FAIL unit_b edge %0d: got lvl=%b prs=%b rel=%b hld=%b, expected %b %b %b %b",
                         edge_n, lvl_b, prs_b, rel_b, hld_b,
                         exp_lvl[1], exp_prs[1], exp_rel[1], exp_hld[1]);
            end
        end
    end

    // Edge numbering: e is the last edge that still sees the old key value.
    initial begin
        int e, pc, hs, rate;
        rst = 1'b0; key_a = 2'b11; key_b = 3'b000;
        ev_press[0] = -1; ev_press[1] = -1; ev_rel[0] = -1; ev_rel[1] = -1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_outputs_a", int'({lvl_a, prs_a, rel_a, hld_a}), 0);

        // Press, long hold with repeat, then release.
        @(negedge clk);
        e = edge_n; hold_log.delete(); key_a[0] = 1'b0;
        repeat (30) @(negedge clk);
        chk("press_latency", ev_press[0], e + 6);
        chk("hold_pulses_seen", int'(hold_log.size() >= 3), 1);
        if (hold_log.size() >= 3) begin
            chk("hold_first", hold_log[0], e + 16);
            chk("hold_repeat1", hold_log[1], e + 19);
            chk("hold_repeat2", hold_log[2], e + 22);
        end
        chk("ch1_quiet", ev_cnt_a1, 0);
        e = edge_n; key_a[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("release_latency", ev_rel[0], e + 6);
        chk("no_hold_after_release", int'(hold_log[hold_log.size()-1] < e + 6), 1);

        // Bounce shorter than the threshold, then settle low.
        pc = press_n;
        key_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        key_a[0] = 1'b1;
        repeat (2) @(negedge clk);
        key_a[0] = 1'b0; e = edge_n;
        repeat (12) @(negedge clk);
        chk("bounce_single_press", press_n, pc + 1);
        chk("bounce_press_edge", ev_press[0], e + 6);
        key_a[0] = 1'b1;
        repeat (12) @(negedge clk);

        // Channel 0 press while channel 1 chatters.
        pc = ev_cnt_a1;
        e = edge_n; key_a[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) key_a[1] = ~key_a[1];
            @(negedge clk);
        end
        key_a[1] = 1'b1;
        repeat (6) @(negedge clk);
        chk("indep_ch0_press", ev_press[0], e + 6);
        chk("indep_ch1_quiet", ev_cnt_a1, pc);
        key_a[0] = 1'b1;
        repeat (20) @(negedge clk);

        // Reset in the middle of a count.
        pc = press_n;
        e = edge_n; key_a[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("reset_mid_press_edge", ev_press[0], e + 11);
        chk("reset_mid_single_press", press_n, pc + 1);
        key_a[0] = 1'b1;
        repeat (20) @(negedge clk);

        // Release flip lands exactly on the first hold threshold.
        e = edge_n; key_a[0] = 1'b0;
        repeat (10) @(negedge clk);
        hold_log.delete();
        key_a[0] = 1'b1;
        repeat (12) @(negedge clk);
        chk("collision_release", ev_rel[0], e + 16);
        chk("collision_no_hold", hold_log.size(), 0);

        // Active-high unit, single-cycle threshold, single hold pulse.
        hold_b.delete();
        e = edge_n; key_b[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("b_press_latency", ev_press[1], e + 3);
        chk("b_hold_count", hold_b.size(), 1);
        if (hold_b.size() >= 1) chk("b_hold_edge", hold_b[0], e + 8);
        key_b[0] = 1'b0;
        repeat (10) @(negedge clk);

        // Random keys with varying chatter rates and occasional resets.
        rate = 8; hs = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(2, 0))
                    0:       rate = 2;
                    1:       rate = 8;
                    default: rate = 30;
                endcase
            end
            for (int c = 0; c < 2; c++) if ($urandom_range(rate - 1, 0) == 0) key_a[c] = ~key_a[c];
            for (int c = 0; c < 3; c++) if ($urandom_range(rate - 1, 0) == 0) key_b[c] = ~key_b[c];
            if (hs > 0) begin
                hs--;
                if (hs == 0) rst = 1'b1;
            end else if ($urandom_range(399, 0) == 0) begin
                rst = 1'b0; hs = int'($urandom_range(3, 1));
            end
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
